// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  // Largest burst length the beat counter is meant to handle.
  localparam int BURST_MAX_LIMIT = 16;

  // Index width for a requester count; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Finds the first set bit of req
// searching upward from last+1, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last,
  output logic               found,
  output logic [IW-1:0]      winner
);

  // Scan offsets from farthest to nearest so the nearest hit is written last
  // and wins; equivalent to rotate / priority-encode / rotate back.
  always_comb begin
    logic [IW-1:0] idx;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the async FIFO write port among NUM_REQ requesters
// with round-robin burst grants. Optional macro FIFO_WR_ARB_PRIO0_EN gives
// requester 0 absolute priority at arbitration time.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]              req_last,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_wr_data,
  output logic [idx_width(NUM_REQ)-1:0]   grant_id,
  output logic                            busy
);

  localparam int IW = idx_width(NUM_REQ);
  // Burst length is clamped to the range the counter is designed for.
  localparam int BM = (BURST_MAX > BURST_MAX_LIMIT) ? BURST_MAX_LIMIT : BURST_MAX;
  localparam int CW = $clog2(BM + 1);

  arb_state_e    state, state_nxt;
  logic [CW-1:0] beat_cnt, cnt_nxt;
  logic [IW-1:0] last_grant;
  logic          rr_found, pick_found;
  logic [IW-1:0] rr_idx, pick_idx;
  logic          in_grant, g_valid, g_last, beat, release_g;

`ifdef FIFO_WR_ARB_PRIO0_EN
  // Requester 0 is excluded from the rotation and overrides it when valid.
  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req    ({req_valid[NUM_REQ-1:1], 1'b0}),
    .last   (last_grant),
    .found  (rr_found),
    .winner (rr_idx)
  );
  assign pick_found = req_valid[0] | rr_found;
  assign pick_idx   = req_valid[0] ? '0 : rr_idx;
`else
  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req    (req_valid),
    .last   (last_grant),
    .found  (rr_found),
    .winner (rr_idx)
  );
  assign pick_found = rr_found;
  assign pick_idx   = rr_idx;
`endif

  // Granted-requester handshake, write-port mux and release decision.
  always_comb begin
    in_grant     = (state == ARB_GRANT);
    g_valid      = req_valid[grant_id];
    g_last       = req_last[grant_id];
    cnt_nxt      = beat_cnt + CW'(1);
    beat         = in_grant && g_valid && !fifo_full;
    req_ready    = '0;
    if (in_grant) req_ready[grant_id] = !fifo_full;
    fifo_wr_en   = beat;
    fifo_wr_data = req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
    busy         = in_grant;
    // A full FIFO freezes the grant, even if the requester drops valid.
    release_g    = in_grant &&
                   ((beat && (g_last || cnt_nxt == CW'(BM))) ||
                    (!g_valid && !fifo_full));
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:  if (pick_found) state_nxt = ARB_GRANT;
      ARB_GRANT: if (release_g)  state_nxt = ARB_IDLE;
      default:   state_nxt = ARB_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  // Grant index, beat counter and rotation pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_id   <= '0;
      beat_cnt   <= '0;
      last_grant <= IW'(NUM_REQ - 1);
    end else if (state == ARB_IDLE) begin
      if (pick_found) begin
        grant_id <= pick_idx;
        beat_cnt <= '0;
      end
    end else begin
      if (beat) beat_cnt <= cnt_nxt;
`ifdef FIFO_WR_ARB_PRIO0_EN
      if (release_g && grant_id != '0) last_grant <= grant_id;
`else
      if (release_g) last_grant <= grant_id;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, BURST_MAX=4).
// Inputs change and outputs are checked in the low phase of clk.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int BM = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             fifo_full;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_wr_data;
  logic [1:0]       grant_id;
  logic             busy;

  int total = 0;
  int bad   = 0;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then let inputs settle.
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    nxt(); nxt();
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      nxt();
      chk("rst_en",   32'(fifo_wr_en), 32'd0);
      chk("rst_busy", 32'(busy),       32'd0);
      chk("rst_gid",  32'(grant_id),   32'd0);
      chk("rst_rdy",  32'(req_ready),  32'd0);
    end

`ifdef FIFO_WR_ARB_PRIO0_EN
    // Requesters 0 and 1 always valid: requester 0 takes every grant.
    req_valid = 4'b0011;
    #1 chk("p_lat_en", 32'(fifo_wr_en), 32'd0);
    for (int c = 0; c < 15; c++) begin
      nxt();
      if (c % 5 < 4) begin
        chk("p_gid", 32'(grant_id),   32'd0);
        chk("p_en",  32'(fifo_wr_en), 32'd1);
      end else begin
        chk("p_bub", 32'(busy), 32'd0);
      end
    end
    // Requester 0 drops valid while idle: requester 1 wins.
    req_valid = 4'b0010;
    nxt();
    chk("p_g1_gid",  32'(grant_id),     32'd1);
    chk("p_g1_busy", 32'(busy),         32'd1);
    chk("p_g1_dat",  32'(fifo_wr_data), 32'hA1);
`else
    // All four valid, no last: grants 0,1,2,3 of 4 beats each, one bubble.
    req_valid = 4'b1111;
    #1 chk("t2_lat_en", 32'(fifo_wr_en), 32'd0);
    begin
      int beats;
      beats = 0;
      for (int c = 0; c < 20; c++) begin
        nxt();
        if (fifo_wr_en) beats++;
        if (c % 5 < 4) begin
          chk("t2_en",  32'(fifo_wr_en),   32'd1);
          chk("t2_gid", 32'(grant_id),     32'(c / 5));
          chk("t2_dat", 32'(fifo_wr_data), 32'(8'hA0 + c / 5));
          chk("t2_rdy", 32'(req_ready),    32'(1 << (c / 5)));
        end else begin
          chk("t2_bub_en",   32'(fifo_wr_en), 32'd0);
          chk("t2_bub_busy", 32'(busy),       32'd0);
        end
      end
      chk("t2_beats", 32'(beats), 32'd16);
    end
    nxt();
    chk("t2_wrap_gid", 32'(grant_id),   32'd0);
    chk("t2_wrap_en",  32'(fifo_wr_en), 32'd1);
    // Requester 0 starves after one beat: released.
    nxt();
    req_valid = '0;
    #1 chk("t2_starve_en",   32'(fifo_wr_en), 32'd0);
    chk("t2_starve_busy", 32'(busy), 32'd1);
    nxt();
    chk("t2_rel_busy", 32'(busy), 32'd0);

    // Requester 2 sends a 2-beat packet.
    req_valid = 4'b0100;
    nxt();
    chk("t3_gid", 32'(grant_id),     32'd2);
    chk("t3_en",  32'(fifo_wr_en),   32'd1);
    chk("t3_dat", 32'(fifo_wr_data), 32'hA2);
    chk("t3_rdy", 32'(req_ready),    32'b0100);
    nxt();
    req_last = 4'b0100;
    #1 chk("t3_b2_en", 32'(fifo_wr_en), 32'd1);
    nxt();
    chk("t3_rel_busy", 32'(busy), 32'd0);
    req_last  = '0;
    req_valid = 4'b1011;
    nxt();
    chk("t3_next_gid", 32'(grant_id), 32'd3);
    chk("t3_next_dat", 32'(fifo_wr_data), 32'hA3);
    req_valid = 4'b1000;

    // FIFO full for 3 cycles after beat 2 of requester 3.
    nxt();
    chk("t4_b2_en", 32'(fifo_wr_en), 32'd1);
    nxt();
    fifo_full = 1'b1;
    #1 chk("t4_f1_en", 32'(fifo_wr_en), 32'd0);
    chk("t4_f1_rdy", 32'(req_ready), 32'd0);
    chk("t4_f1_gid", 32'(grant_id),  32'd3);
    nxt();
    req_valid = 4'b0000;
    #1 chk("t4_f2_en", 32'(fifo_wr_en), 32'd0);
    chk("t4_f2_busy", 32'(busy), 32'd1);
    nxt();
    req_valid = 4'b1000;
    #1 chk("t4_f3_en", 32'(fifo_wr_en), 32'd0);
    chk("t4_f3_busy", 32'(busy),     32'd1);
    chk("t4_f3_gid",  32'(grant_id), 32'd3);
    nxt();
    fifo_full = 1'b0;
    #1 chk("t4_b3_en", 32'(fifo_wr_en),   32'd1);
    chk("t4_b3_dat", 32'(fifo_wr_data), 32'hA3);
    nxt();
    chk("t4_b4_en", 32'(fifo_wr_en), 32'd1);
    nxt();
    chk("t4_rel_busy", 32'(busy),       32'd0);
    chk("t4_rel_en",   32'(fifo_wr_en), 32'd0);

    // One-beat packet from requester 1, then reset mid-burst of requester 2.
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    nxt();
    chk("t5_g1_gid", 32'(grant_id),   32'd1);
    chk("t5_g1_en",  32'(fifo_wr_en), 32'd1);
    nxt();
    chk("t5_g1_rel", 32'(busy), 32'd0);
    req_valid = 4'b0100;
    req_last  = '0;
    nxt();
    chk("t5_g2_gid", 32'(grant_id), 32'd2);
    nxt();
    chk("t5_b2_en", 32'(fifo_wr_en), 32'd1);
    rst_n = 1'b0;
    #1 chk("t5_rst_en", 32'(fifo_wr_en), 32'd0);
    chk("t5_rst_rdy",  32'(req_ready), 32'd0);
    chk("t5_rst_busy", 32'(busy),      32'd0);
    chk("t5_rst_gid",  32'(grant_id),  32'd0);
    req_valid = 4'b0111;
    nxt();
    rst_n = 1'b1;
    nxt();
    chk("t5_post_gid",  32'(grant_id),     32'd0);
    chk("t5_post_busy", 32'(busy),         32'd1);
    chk("t5_post_dat",  32'(fifo_wr_data), 32'hA0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
